spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: single-word SPI master, mode 0 (CPOL=0, CPHA=0), 16-bit words, MSB first.
// The state sequence per word is IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// All serial-side outputs are registered. MISO is brought into the clk domain
// through a two-flop synchronizer.
// Optional macro SPI_MASTER_BURST_EN: when it is defined, the block also accepts a new
// word on the last HOLD cycle and goes straight back to SETUP with ss_n held low.
module spi_master #(
  parameter int CLK_DIV = 4,   // SCK half-period in clk cycles, 2..255
  parameter int CS_GAP  = 8    // minimum ss_n-high time between words, 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        ss_n
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;        // cycle count inside the current phase
  logic [4:0]  half, half_d;      // SCK half-period index in SHIFT; even = high, odd = low
  logic [15:0] tx_sh, tx_sh_d;    // outgoing word, MOSI tracks bit 15
  logic [15:0] rx_sh;             // incoming word, MSB first
  logic        miso_s1, miso_s2;
  logic        accept, fall_evt;
  logic        ss_n_d, sck_d, mosi_d, busy_d, rx_valid_d;

  // Ready is combinational from the registered state so a word can be taken in the ready cycle itself.
`ifdef SPI_MASTER_BURST_EN
  assign tx_ready = (state == IDLE) || ((state == HOLD) && (cnt == DIV_LAST));
`else
  assign tx_ready = (state == IDLE);
`endif

  assign accept   = tx_valid && tx_ready;
  // Last high-phase cycle of an SCK period: sample MISO here and move MOSI on as SCK falls.
  assign fall_evt = (state == SHIFT) && (cnt == DIV_LAST) && !half[0];

  // State and phase counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      half  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      half  <= half_d;
    end
  end

  // Next state: each timed phase ends when its counter reaches the last cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state;
    cnt_d   = cnt + 8'd1;
    half_d  = half;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        if (cnt == DIV_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half + 5'd1;   // wraps back to 0 after the 32nd half-period
          if (half == 5'd31) state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt == DIV_LAST) begin
          cnt_d   = '0;
          state_d = accept ? SETUP : GAP;   // accept can only be high here in burst builds
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs, derived from the next state.
  always_comb begin
    tx_sh_d = tx_sh;
    if (accept)        tx_sh_d = tx_data;
    else if (fall_evt) tx_sh_d = {tx_sh[14:0], 1'b0};
    ss_n_d     = !(state_d inside {SETUP, SHIFT, HOLD});
    sck_d      = (state_d == SHIFT) && !half_d[0];
    mosi_d     = ss_n_d ? 1'b0 : tx_sh_d[15];
    busy_d     = (state_d != IDLE);
    rx_valid_d = (state == SHIFT) && (state_d == HOLD);
  end

  // MISO synchronizer; MISO is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= MISO;
      miso_s2 <= miso_s1;
    end
  end

  // Registered outputs and data shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      ss_n     <= 1'b1;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
    end else begin
      tx_sh    <= tx_sh_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
      ss_n     <= ss_n_d;
      SCK      <= sck_d;
      MOSI     <= mosi_d;
      if (fall_evt)   rx_sh   <= {rx_sh[14:0], miso_s2};
      if (rx_valid_d) rx_data <= rx_sh;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: two spi_master instances (CLK_DIV=4 and CLK_DIV=2). Each one has
// its own directed and random stimulus, a bus-level slave, and a timeline model. The
// model predicts every output from the word's position (cycles since acceptance).
// Build with SPI_MASTER_BURST_EN defined to check the burst variant.
module tb_spi_master;

  localparam int CS_GAP = 8;
`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SCK level at position k after acceptance: SETUP for d cycles, then 16 periods, each d high and d low.
  function automatic logic exp_sck(input int d, input int k);
    return (k >= d) && (k < 33 * d) && (((k - d) % (2 * d)) < d);
  endfunction

  // MOSI at position k: the bit indexed by the number of SCK falls seen so far; 0 once all 16 have gone.
  function automatic logic exp_mosi(input int d, input int k, input logic [15:0] w);
    int nf;
    if (k >= 34 * d) return 1'b0;
    nf = (k < 2 * d) ? 0 : ((k - 2 * d) / (2 * d) + 1);
    if (nf >= 16) return 1'b0;
    return w[15 - nf];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = (g == 0) ? 4 : 2;

    logic        rst_n, tx_valid, tx_ready, rx_valid, busy, sck, mosi, miso, ss_n;
    logic [15:0] tx_data, rx_data;
    bit          done = 1'b0;

    spi_master #(.CLK_DIV(D), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .SCK(sck), .MOSI(mosi), .MISO(miso), .ss_n(ss_n)
    );

    // Slave: shifts s_word out on SCK falls and captures MOSI on SCK rises; optional loopback.
    bit          loopback = 1'b1;
    logic [15:0] s_word = '0, s_sh = '0, s_cap = '0;
    int          rise_cnt = 0;
    logic        ss_prev = 1'b1, sck_prev = 1'b0;
    assign miso = loopback ? mosi : s_sh[15];

    always @(negedge clk) begin
      if (ss_prev && !ss_n) begin
        s_sh     = s_word;
        rise_cnt = 0;
      end else if (sck_prev && !sck) begin
        s_sh = {s_sh[14:0], 1'b0};
      end
      if (!sck_prev && sck) begin
        s_cap = {s_cap[14:0], mosi};
        rise_cnt++;
      end
      ss_prev  = ss_n;
      sck_prev = sck;
    end

    // Timeline model and per-cycle compare, plus ss_n run-length and rx_valid monitors.
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [15:0] m_word = '0, m_exp_rx = '0, m_rx = '0;
    logic        e_ready, e_ss, e_sck, e_mosi, e_busy, e_rxv;
    int          lo_len = 0, last_lo = 0, hi_len = 0, last_hi = 0, n_rxv = 0;

    always @(negedge clk) begin
      if (!rst_n) begin
        m_active = 1'b0;
        m_rx     = '0;
        check($sformatf("D%0d rst ss_n", D), 32'(ss_n), 32'h1);
        check($sformatf("D%0d rst sck", D), 32'(sck), 32'h0);
        check($sformatf("D%0d rst mosi", D), 32'(mosi), 32'h0);
        check($sformatf("D%0d rst busy", D), 32'(busy), 32'h0);
        check($sformatf("D%0d rst rx_valid", D), 32'(rx_valid), 32'h0);
        check($sformatf("D%0d rst rx_data", D), 32'(rx_data), 32'h0);
      end else begin
        e_ready = !m_active || (BURST && (m_k == 34 * D - 1));
        if (m_active) begin
          e_ss   = (m_k >= 34 * D);
          e_sck  = exp_sck(D, m_k);
          e_mosi = exp_mosi(D, m_k, m_word);
          e_busy = 1'b1;
          e_rxv  = (m_k == 33 * D);
        end else begin
          e_ss   = 1'b1;
          e_sck  = 1'b0;
          e_mosi = 1'b0;
          e_busy = 1'b0;
          e_rxv  = 1'b0;
        end
        if (e_rxv) m_rx = m_exp_rx;
        check($sformatf("D%0d tx_ready k=%0d", D, m_k), 32'(tx_ready), 32'(e_ready));
        check($sformatf("D%0d ss_n k=%0d", D, m_k), 32'(ss_n), 32'(e_ss));
        check($sformatf("D%0d sck k=%0d", D, m_k), 32'(sck), 32'(e_sck));
        check($sformatf("D%0d mosi k=%0d", D, m_k), 32'(mosi), 32'(e_mosi));
        check($sformatf("D%0d busy k=%0d", D, m_k), 32'(busy), 32'(e_busy));
        check($sformatf("D%0d rx_valid k=%0d", D, m_k), 32'(rx_valid), 32'(e_rxv));
        check($sformatf("D%0d rx_data k=%0d", D, m_k), 32'(rx_data), 32'(m_rx));
        if (tx_valid && e_ready) begin
          m_active = 1'b1;
          m_k      = 0;
          m_word   = tx_data;
          m_exp_rx = loopback ? tx_data : s_word;
        end else if (m_active) begin
          m_k++;
          if (m_k == 34 * D + CS_GAP) m_active = 1'b0;
        end
      end
      if (!ss_n) lo_len++;
      else begin
        if (lo_len != 0) last_lo = lo_len;
        lo_len = 0;
      end
      if (ss_n) hi_len++;
      else begin
        if (hi_len != 0) last_hi = hi_len;
        hi_len = 0;
      end
      if (rx_valid) n_rxv++;
    end

    // Waits until tx_ready is seen away from the edge; the following posedge accepts.
    task automatic wait_ready(input int limit);
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!tx_ready && t < limit);
      check($sformatf("D%0d wait tx_ready", D), 32'(tx_ready), 32'h1);
      @(posedge clk);
      #1;
    endtask

    task automatic wait_idle(input int base, input int n_words);
      int t = 0;
      while (n_rxv < base + n_words && t < 100 * D * n_words + 200) begin
        @(posedge clk); #1;
        tx_data = 16'($urandom);   // in-flight noise on tx_data must not matter
        t++;
      end
      check($sformatf("D%0d rx_valid pulses", D), 32'(n_rxv - base), 32'(n_words));
      t = 0;
      while (busy && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      check($sformatf("D%0d back to idle", D), 32'(busy), 32'h0);
    endtask

    task automatic send(input logic [15:0] w, input bit lb, input logic [15:0] sw);
      int base;
      base     = n_rxv;
      loopback = lb;
      s_word   = sw;
      tx_data  = w;
      tx_valid = 1'b1;
      wait_ready(50);
      tx_valid = 1'b0;
      wait_idle(base, 1);
    endtask

    logic [15:0] r_w, r_sw;
    bit          r_lb;
    int          base, idle, t;

    initial begin
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("D%0d reset tx_ready", D), 32'(tx_ready), 32'h1);
      check($sformatf("D%0d reset ss_n", D), 32'(ss_n), 32'h1);
      check($sformatf("D%0d reset rx_data", D), 32'(rx_data), 32'h0);
      rst_n = 1'b1;

      // Loopback word: MOSI sequence, received word, ss_n low time.
      send(16'h09BB, 1'b1, 16'h0000);
      check($sformatf("D%0d loop rx_data", D), 32'(rx_data), 32'h09BB);
      check($sformatf("D%0d loop mosi bits", D), 32'(s_cap), 32'b0000100110111011);
      check($sformatf("D%0d loop ss_n low", D), 32'(last_lo), (D == 4) ? 32'd136 : 32'd68);
      check($sformatf("D%0d loop sck rises", D), 32'(rise_cnt), 32'd16);

      // Slave returns A55A while 1234 goes out.
      send(16'h1234, 1'b0, 16'hA55A);
      check($sformatf("D%0d slave rx_data", D), 32'(rx_data), 32'hA55A);
      check($sformatf("D%0d slave mosi bits", D), 32'(s_cap), 32'h1234);

      // tx_valid held across two words.
      base = n_rxv; loopback = 1'b1;
      tx_data = 16'h0001; tx_valid = 1'b1;
      wait_ready(50);
      tx_data = 16'h8000;
      wait_ready(40 * D + 100);
      tx_valid = 1'b0;
      wait_idle(base, 2);
      check($sformatf("D%0d pair rx_data", D), 32'(rx_data), 32'h8000);
`ifdef SPI_MASTER_BURST_EN
      check($sformatf("D%0d burst sck rises", D), 32'(rise_cnt), 32'd32);
      check($sformatf("D%0d burst ss_n low", D), 32'(last_lo), 32'(68 * D));
`else
      check($sformatf("D%0d pair gap>=CS_GAP", D), 32'(last_hi >= CS_GAP), 32'h1);
      check($sformatf("D%0d pair sck rises", D), 32'(rise_cnt), 32'd16);
`endif

      // Reset after the 7th SCK rise, then a clean word.
      base = n_rxv; loopback = 1'b0; s_word = 16'h5A5A;
      tx_data = 16'hC3A5; tx_valid = 1'b1;
      wait_ready(50);
      tx_valid = 1'b0;
      @(negedge clk); #1;
      t = 0;
      while (rise_cnt < 7 && t < 40 * D) begin
        @(posedge clk); #1;
        t++;
      end
      check($sformatf("D%0d reached 7th rise", D), 32'(rise_cnt), 32'd7);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check($sformatf("D%0d midword ss_n", D), 32'(ss_n), 32'h1);
      check($sformatf("D%0d midword sck", D), 32'(sck), 32'h0);
      check($sformatf("D%0d midword busy", D), 32'(busy), 32'h0);
      check($sformatf("D%0d midword rx_data", D), 32'(rx_data), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check($sformatf("D%0d no rx_valid after abort", D), 32'(n_rxv - base), 32'h0);
      send(16'hFFFF, 1'b1, 16'h0000);
      check($sformatf("D%0d post-reset rx_data", D), 32'(rx_data), 32'hFFFF);
      check($sformatf("D%0d post-reset sck rises", D), 32'(rise_cnt), 32'd16);

      // Random words, random slave data, random idle spacing.
      for (int i = 0; i < 25; i++) begin
        r_w  = 16'($urandom);
        r_sw = 16'($urandom);
        r_lb = ($urandom_range(0, 1) == 1);
        idle = int'($urandom_range(0, 4));
        repeat (idle) begin
          @(posedge clk); #1;
        end
        send(r_w, r_lb, r_sw);
        check($sformatf("D%0d rand%0d rx_data", D, i), 32'(rx_data), 32'(r_lb ? r_w : r_sw));
        check($sformatf("D%0d rand%0d mosi bits", D, i), 32'(s_cap), 32'(r_w));
      end
      done = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(u[0].done && u[1].done) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    check("global completion", 32'(u[0].done && u[1].done), 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
